// File: rtl/prach_avst_pattern_gen.sv
// PRACH Avalon-ST pattern generator.
// Emits cfg_len*NUM_CHN beats, one per clock. One antenna lane on one TDM
// channel carries a pattern: zeros, a single impulse, or test-vector replay.
// The pipeline has three stages:
//   gen  : beat counters and tv_addr (edge E_b for beat b)
//   p1   : slot decode while the test-vector memory returns data (E_b+1)
//   out  : registered Avalon-ST outputs (E_b+2)
// The test-vector memory is expected to be a synchronous-read RAM. It samples
// tv_addr on the edge before the output edge, so tv_rd_data is valid exactly
// when the p1 stage needs it.
module prach_avst_pattern_gen #(
    parameter int NUM_ANT  = 8,
    parameter int NUM_CHN  = 4,
    parameter int SAMPLE_W = 32,
    parameter int TV_DEPTH = 30720,
    localparam int ADDR_W  = (TV_DEPTH > 1) ? $clog2(TV_DEPTH) : 1,
    localparam int ANT_W   = $clog2(NUM_ANT) + 1,
    localparam int CHN_W   = $clog2(NUM_CHN) + 1
) (
    input  logic                         clk_jesd,
    input  logic                         rst_jesd_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [1:0]                   cfg_mode,
    input  logic [ANT_W-1:0]             cfg_ant,
    input  logic [CHN_W-1:0]             cfg_chn,
    input  logic [31:0]                  cfg_len,
    input  logic [31:0]                  cfg_sync_offset,
    input  logic [SAMPLE_W-1:0]          cfg_impulse,
    output logic [ADDR_W-1:0]            tv_addr,
    input  logic [SAMPLE_W-1:0]          tv_rd_data,
    output logic [NUM_ANT*SAMPLE_W-1:0]  avst_sink_data,
    output logic                         avst_sink_valid,
    output logic [7:0]                   avst_sink_channel,
    output logic                         sync_out,
    output logic                         busy,
    output logic                         done
);

    localparam int DW    = NUM_ANT * SAMPLE_W;
    // The beat counter holds cfg_len*NUM_CHN - 1 without wrapping.
    localparam int CNT_W = (32 + CHN_W > 34) ? 32 + CHN_W : 34;

    localparam logic [1:0] MODE_IMPULSE = 2'd2;
    localparam logic [1:0] MODE_TV      = 2'd3;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                state_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic [1:0]            nop_pipe_reg;

    // Configuration latched at start.
    logic [1:0]            mode_reg;
    logic [ANT_W-1:0]      ant_reg;
    logic [CHN_W-1:0]      chn_reg;
    logic [31:0]           len_reg;
    logic [31:0]           sync_off_reg;
    logic [SAMPLE_W-1:0]   impulse_reg;

    // Generator stage.
    logic                  gen_valid_reg;
    logic [31:0]           gen_idx_reg;
    logic [CHN_W-1:0]      gen_chn_reg;
    logic [CNT_W-1:0]      gen_beat_reg;
    logic [ADDR_W-1:0]     tv_addr_reg;

    // Decode stage, aligned with tv_rd_data.
    logic                  p1_valid_reg;
    logic [CHN_W-1:0]      p1_chn_reg;
    logic                  p1_active_reg;
    logic                  p1_first_reg;
    logic                  p1_sync_reg;
    logic                  p1_last_reg;

    // Output stage.
    logic [DW-1:0]         data_reg;
    logic                  valid_reg;
    logic [7:0]            channel_reg;
    logic                  sync_reg;
    logic                  out_last_reg;

    logic                  run_active;
    logic                  abort_hit;
    logic                  start_go;
    logic                  start_nop;
    logic                  gen_last;
    logic [SAMPLE_W-1:0]   lane_val;
    logic [DW-1:0]         data_next;

    assign run_active = (state_reg == S_RUN);
    assign abort_hit  = run_active && abort;
    assign start_go   = (state_reg == S_IDLE) && start &&
                        (cfg_mode != 2'd0) && (cfg_len != 32'd0);
    assign start_nop  = (state_reg == S_IDLE) && start &&
                        ((cfg_mode == 2'd0) || (cfg_len == 32'd0));
    assign gen_last   = (gen_idx_reg == len_reg - 32'd1) &&
                        (gen_chn_reg == CHN_W'(NUM_CHN - 1));

    // Run control: IDLE/RUN sequencing, busy, and the done pulse (normal or no-op).
    always_ff @(posedge clk_jesd or negedge rst_jesd_n) begin
        if (!rst_jesd_n) begin
            state_reg    <= S_IDLE;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            nop_pipe_reg <= 2'b00;
        end else begin
            nop_pipe_reg <= {nop_pipe_reg[0], start_nop};
            done_reg     <= nop_pipe_reg[1];
            case (state_reg)
                S_IDLE: begin
                    if (start_go) begin
                        state_reg <= S_RUN;
                        busy_reg  <= 1'b1;
                    end
                end
                S_RUN: begin
                    // The last beat is on the outputs, or an abort is requested.
                    if (abort || out_last_reg) begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Generator: latch the configuration and step sample/channel/beat counters and tv_addr.
    always_ff @(posedge clk_jesd or negedge rst_jesd_n) begin
        if (!rst_jesd_n) begin
            mode_reg      <= 2'd0;
            ant_reg       <= '0;
            chn_reg       <= '0;
            len_reg       <= 32'd0;
            sync_off_reg  <= 32'd0;
            impulse_reg   <= '0;
            gen_valid_reg <= 1'b0;
            gen_idx_reg   <= 32'd0;
            gen_chn_reg   <= '0;
            gen_beat_reg  <= '0;
            tv_addr_reg   <= '0;
        end else if (start_go) begin
            mode_reg      <= cfg_mode;
            ant_reg       <= cfg_ant;
            chn_reg       <= cfg_chn;
            len_reg       <= cfg_len;
            sync_off_reg  <= cfg_sync_offset;
            impulse_reg   <= cfg_impulse;
            gen_valid_reg <= 1'b1;
            gen_idx_reg   <= 32'd0;
            gen_chn_reg   <= '0;
            gen_beat_reg  <= '0;
            tv_addr_reg   <= '0;
        end else if (abort_hit) begin
            gen_valid_reg <= 1'b0;
        end else if (gen_valid_reg) begin
            if (gen_last) begin
                gen_valid_reg <= 1'b0;
            end else begin
                gen_beat_reg <= gen_beat_reg + CNT_W'(1);
                if (gen_chn_reg == CHN_W'(NUM_CHN - 1)) begin
                    gen_chn_reg <= '0;
                    gen_idx_reg <= gen_idx_reg + 32'd1;
                    if (tv_addr_reg == ADDR_W'(TV_DEPTH - 1)) begin
                        tv_addr_reg <= '0;
                    end else begin
                        tv_addr_reg <= tv_addr_reg + ADDR_W'(1);
                    end
                end else begin
                    gen_chn_reg <= gen_chn_reg + CHN_W'(1);
                end
            end
        end
    end

    // Decode: find the active slot, first sample, sync beat and last beat while memory reads.
    always_ff @(posedge clk_jesd or negedge rst_jesd_n) begin
        if (!rst_jesd_n) begin
            p1_valid_reg  <= 1'b0;
            p1_chn_reg    <= '0;
            p1_active_reg <= 1'b0;
            p1_first_reg  <= 1'b0;
            p1_sync_reg   <= 1'b0;
            p1_last_reg   <= 1'b0;
        end else if (abort_hit) begin
            p1_valid_reg  <= 1'b0;
            p1_chn_reg    <= '0;
            p1_active_reg <= 1'b0;
            p1_first_reg  <= 1'b0;
            p1_sync_reg   <= 1'b0;
            p1_last_reg   <= 1'b0;
        end else begin
            p1_valid_reg  <= gen_valid_reg;
            p1_chn_reg    <= gen_chn_reg;
            // gen_chn never reaches NUM_CHN, so an out-of-range cfg_chn never matches.
            p1_active_reg <= gen_valid_reg && (gen_chn_reg == chn_reg);
            p1_first_reg  <= (gen_idx_reg == 32'd0);
            p1_sync_reg   <= gen_valid_reg && (gen_beat_reg == CNT_W'(sync_off_reg));
            p1_last_reg   <= gen_valid_reg && gen_last;
        end
    end

    // Pattern value for the active lane on this beat.
    always_comb begin
        lane_val = '0;
        if (p1_active_reg) begin
            case (mode_reg)
                MODE_IMPULSE: lane_val = p1_first_reg ? impulse_reg : '0;
                MODE_TV:      lane_val = tv_rd_data;
                default:      lane_val = '0;
            endcase
        end
    end

    // Lane 0 occupies the MSBs. An out-of-range cfg_ant matches no lane.
    generate
        for (genvar gi = 0; gi < NUM_ANT; gi++) begin : g_lane
            assign data_next[DW-1-SAMPLE_W*gi -: SAMPLE_W] =
                (ant_reg == ANT_W'(gi)) ? lane_val : '0;
        end
    endgenerate

    // Output register. Idle, abort and post-run beats are all-zero with valid low.
    always_ff @(posedge clk_jesd or negedge rst_jesd_n) begin
        if (!rst_jesd_n) begin
            data_reg     <= '0;
            valid_reg    <= 1'b0;
            channel_reg  <= 8'd0;
            sync_reg     <= 1'b0;
            out_last_reg <= 1'b0;
        end else if (abort_hit || !p1_valid_reg) begin
            data_reg     <= '0;
            valid_reg    <= 1'b0;
            channel_reg  <= 8'd0;
            sync_reg     <= 1'b0;
            out_last_reg <= 1'b0;
        end else begin
            data_reg     <= data_next;
            valid_reg    <= 1'b1;
            channel_reg  <= 8'(p1_chn_reg);
            sync_reg     <= p1_sync_reg;
            out_last_reg <= p1_last_reg;
        end
    end

    assign tv_addr           = tv_addr_reg;
    assign avst_sink_data    = data_reg;
    assign avst_sink_valid   = valid_reg;
    assign avst_sink_channel = channel_reg;
    assign sync_out          = sync_reg;
    assign busy              = busy_reg;
    assign done              = done_reg;

endmodule

// File: doc/prach_avst_pattern_gen.md
PRACH_AVST_PATTERN_GEN -- requirements
Module: prach_avst_pattern_gen

Interface
REQ-001 SHALL have parameter NUM_ANT, default 8, antenna lanes per beat.
REQ-002 SHALL have parameter NUM_CHN, default 4, TDM channels per sample period.
REQ-003 SHALL have parameter SAMPLE_W, default 32, bits per antenna lane ({I,Q}).
REQ-004 SHALL have parameter TV_DEPTH, default 30720, test-vector memory depth; ADDR_W = clog2(TV_DEPTH).
REQ-005 SHALL have ports: clk_jesd  in  1  sole clock; rst_jesd_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: start  in  1  run request pulse; abort  in  1  stop request; cfg_mode  in  2  0 zero-idle, 1 flush, 2 impulse, 3 TV replay.
REQ-007 SHALL have ports: cfg_ant  in  clog2(NUM_ANT)+1  active lane; cfg_chn  in  clog2(NUM_CHN)+1  active channel; cfg_len  in  32  sample periods; cfg_sync_offset  in  32  beat index of sync pulse; cfg_impulse  in  SAMPLE_W  impulse value.
REQ-008 SHALL have ports: tv_addr  out  ADDR_W  memory read address; tv_rd_data  in  SAMPLE_W  memory data, valid 1 cycle after tv_addr.
REQ-009 SHALL have ports: avst_sink_data  out  NUM_ANT*SAMPLE_W; avst_sink_valid  out  1; avst_sink_channel  out  8; sync_out  out  1; busy  out  1; done  out  1.

Function
REQ-010 SHALL implement FSM IDLE -> RUN -> IDLE; start sampled high in IDLE with cfg_mode != 0 and cfg_len != 0 enters RUN and latches all cfg_* inputs.
REQ-011 SHALL ignore start while busy; SHALL ignore cfg_* changes during RUN.
REQ-012 SHALL, for start with cfg_len == 0 or cfg_mode == 0, stay IDLE and pulse done one cycle, 2 edges after start sampled, with no valid beat.
REQ-013 SHALL generate cfg_len*NUM_CHN consecutive beats, one per clock, no gaps; beat b has sample index i = b/NUM_CHN, channel c = b mod NUM_CHN.
REQ-014 SHALL drive avst_sink_channel = c, zero-extended, on every valid beat.
REQ-015 SHALL place lane a at bits [NUM_ANT*SAMPLE_W-1-SAMPLE_W*a -: SAMPLE_W] (lane 0 in MSBs).
REQ-016 SHALL zero all lanes except lane cfg_ant on channel cfg_chn, which carries: flush 0; impulse cfg_impulse when i == 0 else 0; TV replay tv_rd_data for index i.
REQ-017 SHALL drive tv_addr = i mod TV_DEPTH one cycle before the beat's output edge (address wraps to 0 after TV_DEPTH-1).
REQ-018 SHALL treat cfg_ant >= NUM_ANT or cfg_chn >= NUM_CHN as no active slot (all-zero valid beats).
REQ-019 SHALL register all outputs; beat 0 appears on the 2nd rising edge after the edge sampling start.
REQ-020 SHALL assert busy from the edge sampling start until the edge done asserts.
REQ-021 SHALL, after the last beat, on the next edge deassert valid, zero data and channel, pulse done for one cycle, deassert busy.
REQ-022 SHALL pulse sync_out one cycle coincident with beat b == cfg_sync_offset; no pulse if cfg_sync_offset >= cfg_len*NUM_CHN.
REQ-023 SHALL, on abort high in RUN, on the next edge deassert valid and sync_out, zero data and channel, pulse done, return IDLE; abort in IDLE ignored; abort wins over the last beat if simultaneous.
REQ-024 SHALL use a counter of at least 34 bits for beat count; no overflow for cfg_len up to 2^32-1.

Reset
REQ-025 SHALL, on rst_jesd_n low, immediately force IDLE, avst_sink_data 0, avst_sink_valid 0, avst_sink_channel 0, sync_out 0, busy 0, done 0, tv_addr 0, regardless of run state.
REQ-026 SHALL, after reset release, require a new start; no residual beats.

Verification
REQ-027 SHALL verify TV replay: mode 3, ant 0, chn 0, len 30720, memory[k]=k -> 122880 contiguous beats, channel 0,1,2,3 repeating, bits[255:224]=k on channel 0, all else 0, done once.
REQ-028 SHALL verify impulse: mode 2, ant 0, chn 0, len 1000, impulse 16384 -> beat 0 bits[255:224]=16384, remaining 3999 beats all zero, valid continuous.
REQ-029 SHALL verify sync: cfg_sync_offset 5, len 4 -> sync_out high only with beat 5 (i=1, channel 1); offset 16 -> no pulse.
REQ-030 SHALL verify wrap: TV_DEPTH 8, len 10 -> tv_addr sequence per sample 0..7,0,1; lane 3 placement when ant 3 selects bits[159:128].
REQ-031 SHALL verify abort at beat 7 and start-while-busy -> valid low next edge, one done pulse, second start ignored; cfg_len 0 -> done only, no valid.
REQ-032 SHALL verify reset asserted at beat 50 -> all outputs 0 asynchronously, no done, IDLE after release.
